// File: rtl/pc_fetch_gen_pkg.sv
// pc_fetch_pkg: shared state encoding and default constants for pc_fetch_gen.
package pc_fetch_pkg;

    // FSM encoding kept as plain constants for compatibility with legacy code
    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT  = 2'd0;
    localparam pc_state_t ST_RUN   = 2'd1;
    localparam pc_state_t ST_FLUSH = 2'd2;

    localparam int unsigned DEFAULT_STEP     = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = '0;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// pc_fetch_gen_if: fetch-request bus between the PC generator (master) and
// IMEM / branch resolution (slave).
interface pc_fetch_gen_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 32
);
    logic             STALL;
    logic             BR_TAKEN;
    logic [WIDTH-1:0] BR_TARGET;
    logic             PC_READY;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PC_PLUS;
    logic             PC_VALID;
    logic [CNT_W-1:0] FETCH_CNT;
    logic             MISALIGN;

    modport master (
        input  STALL, BR_TAKEN, BR_TARGET, PC_READY,
        output PC, PC_PLUS, PC_VALID, FETCH_CNT, MISALIGN
    );

    modport slave (
        output STALL, BR_TAKEN, BR_TARGET, PC_READY,
        input  PC, PC_PLUS, PC_VALID, FETCH_CNT, MISALIGN
    );
endinterface

// File: rtl/pc_fetch_gen_step_adder.sv
// pc_step_adder: PC + STEP, truncated to WIDTH so the PC wraps naturally.
module pc_step_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned STEP  = 4
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] pc_plus_o
);
    // Purely combinational successor address
    always_comb begin
        pc_plus_o = pc_i + WIDTH'(STEP);
    end
endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: fetch PC register with valid/ready handshake, branch redirect,
// post-redirect bubble and saturating fetch counter.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_gen
    import pc_fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 64,
    parameter int unsigned      STEP     = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      CNT_W    = 32
) (
    input logic            CLK,
    input logic            RESET,
    pc_fetch_gen_if.master bus
);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_plus;
    logic             valid;
    logic             accept;

    pc_step_adder #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step_adder (
        .pc_i      (pc_q),
        .pc_plus_o (pc_plus)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    // Sticky flag for a redirect to a target that is not word aligned
    always_comb begin
        mis_d = mis_q;
        if (bus.BR_TAKEN && (bus.BR_TARGET[1:0] != 2'b00)) begin
            mis_d = 1'b1;
        end
    end

    // Misalign flag register; only reset clears it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
`else
    logic mis_q;
    assign mis_q = 1'b0;
`endif

    assign valid  = (state_q == ST_RUN);
    assign accept = valid && bus.PC_READY && !bus.STALL && !bus.BR_TAKEN;

    // Next-state: branch beats stall beats accept; a misaligned redirect pins FLUSH
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (bus.BR_TAKEN) begin
            state_d = ST_FLUSH;
            pc_d    = bus.BR_TARGET;
        end else if (!bus.STALL) begin
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_FLUSH: state_d = mis_q ? ST_FLUSH : ST_RUN;
                ST_RUN: begin
                    if (accept) begin
                        pc_d = pc_plus;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    // State, PC and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PC        = pc_q;
    assign bus.PC_PLUS   = pc_plus;
    assign bus.PC_VALID  = valid;
    assign bus.FETCH_CNT = cnt_q;
    assign bus.MISALIGN  = mis_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: directed scoreboard bench for pc_fetch_gen. A second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_pc_fetch_gen;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    pc_fetch_gen_if #(.WIDTH(64), .CNT_W(32)) bus0 ();
    pc_fetch_gen_if #(.WIDTH(64), .CNT_W(2))  bus1 ();

    assign bus1.STALL     = bus0.STALL;
    assign bus1.BR_TAKEN  = bus0.BR_TAKEN;
    assign bus1.BR_TARGET = bus0.BR_TARGET;
    assign bus1.PC_READY  = bus0.PC_READY;

    pc_fetch_gen #(.WIDTH(64), .STEP(4), .RESET_PC(64'h0), .CNT_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus0.master)
    );

    pc_fetch_gen #(.WIDTH(64), .STEP(4), .RESET_PC(64'h0), .CNT_W(2)) dut_sat (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus1.master)
    );

    typedef struct {
        logic [63:0] pc;
        logic        valid;
        logic [31:0] cnt;
        logic [1:0]  cnt2;
        logic        mis;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Reference model state (0=BOOT, 1=RUN, 2=FLUSH)
    int          m_state;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    int          m_cnt2;
    logic        m_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic stall, input logic br,
                              input logic [63:0] tgt, input logic rdy);
        if (rst) begin
            m_state = 0; m_pc = '0; m_cnt = '0; m_cnt2 = 0; m_mis = 1'b0;
        end else if (br) begin
            m_pc    = tgt;
            m_state = 2;
`ifdef PC_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
`endif
        end else if (!stall) begin
            if (m_state == 0) m_state = 1;
            else if (m_state == 2) m_state = m_mis ? 2 : 1;
            else if (rdy) begin
                m_pc = m_pc + 64'd4;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
        end
    endtask

    // One clock: drive inputs, push the expected post-edge outputs, then compare
    task automatic cyc(input string tag, input logic rst, input logic stall, input logic br,
                       input logic [63:0] tgt, input logic rdy);
        exp_t e;
        RESET          = rst;
        bus0.STALL     = stall;
        bus0.BR_TAKEN  = br;
        bus0.BR_TARGET = tgt;
        bus0.PC_READY  = rdy;
        model_step(rst, stall, br, tgt, rdy);
        e.pc    = m_pc;
        e.valid = (m_state == 1);
        e.cnt   = m_cnt;
        e.cnt2  = 2'(m_cnt2);
        e.mis   = m_mis;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        chk({tag, ".pc"},     bus0.PC,                e.pc);
        chk({tag, ".pcplus"}, bus0.PC_PLUS,           e.pc + 64'd4);
        chk({tag, ".valid"},  64'(bus0.PC_VALID),     64'(e.valid));
        chk({tag, ".cnt"},    64'(bus0.FETCH_CNT),    64'(e.cnt));
        chk({tag, ".mis"},    64'(bus0.MISALIGN),     64'(e.mis));
        chk({tag, ".pc2"},    bus1.PC,                e.pc);
        chk({tag, ".cnt2"},   64'(bus1.FETCH_CNT),    64'(e.cnt2));
        chk({tag, ".valid2"}, 64'(bus1.PC_VALID),     64'(e.valid));
        chk({tag, ".pcplus2"},bus1.PC_PLUS,           e.pc + 64'd4);
        chk({tag, ".mis2"},   64'(bus1.MISALIGN),     64'(e.mis));
    endtask

    initial begin
        RESET = 1'b1; bus0.STALL = 1'b0; bus0.BR_TAKEN = 1'b0;
        bus0.BR_TARGET = '0; bus0.PC_READY = 1'b0;
        m_state = 0; m_pc = '0; m_cnt = '0; m_cnt2 = 0; m_mis = 1'b0;
        #2;

        // 1: reset, then four ready cycles: bubble, then 0,4,8,12
        cyc("t1.rst", 1, 0, 0, 64'h0, 1);
        chk("t1.rst_valid", 64'(bus0.PC_VALID), 64'd0);
        for (int i = 0; i < 4; i++) cyc("t1.run", 0, 0, 0, 64'h0, 1);
        chk("t1.pc12", bus0.PC, 64'd12);
        chk("t1.cnt3", 64'(bus0.FETCH_CNT), 64'd3);

        // 2: reach 0x20, stall 3 cycles, release
        for (int i = 0; i < 5; i++) cyc("t2.adv", 0, 0, 0, 64'h0, 1);
        chk("t2.pc20", bus0.PC, 64'h20);
        for (int i = 0; i < 3; i++) cyc("t2.stall", 0, 1, 0, 64'h0, 1);
        cyc("t2.release", 0, 0, 0, 64'h0, 1);
        chk("t2.pc24", bus0.PC, 64'h24);
        chk("t2.sat", 64'(bus1.FETCH_CNT), 64'd3);

        // IMEM not ready: PC and valid hold
        for (int i = 0; i < 2; i++) cyc("nrdy", 0, 0, 0, 64'h0, 0);

        // 3: branch under stall from 0x40
        for (int i = 0; i < 7; i++) cyc("t3.adv", 0, 0, 0, 64'h0, 1);
        chk("t3.pc40", bus0.PC, 64'h40);
        cyc("t3.br", 0, 1, 1, 64'h100, 1);
        chk("t3.flush_valid", 64'(bus0.PC_VALID), 64'd0);
        cyc("t3.after", 0, 0, 0, 64'h0, 1);
        chk("t3.pc100", bus0.PC, 64'h100);

        // 4: back-to-back branches
        cyc("t4.br1", 0, 0, 1, 64'h200, 1);
        cyc("t4.br2", 0, 0, 1, 64'h300, 1);
        cyc("t4.run", 0, 0, 0, 64'h0, 1);
        chk("t4.valid300", 64'(bus0.PC_VALID), 64'd1);
        cyc("t4.acc", 0, 0, 0, 64'h0, 1);

        // stall during FLUSH holds the bubble
        cyc("fl.br", 0, 0, 1, 64'h400, 1);
        cyc("fl.stall", 0, 1, 0, 64'h0, 1);
        cyc("fl.go", 0, 0, 0, 64'h0, 1);

        // 5: wrap past 2^64-1
        cyc("t5.br", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        cyc("t5.run", 0, 0, 0, 64'h0, 1);
        cyc("t5.wrap", 0, 0, 0, 64'h0, 1);
        chk("t5.pc0", bus0.PC, 64'h0);

        // reset wins over branch and stall
        cyc("rst.mid", 1, 1, 1, 64'h500, 1);
        cyc("boot.br", 0, 0, 1, 64'h600, 1);
        cyc("boot.run", 0, 0, 0, 64'h0, 1);
        cyc("boot.acc", 0, 0, 0, 64'h0, 1);

        // 6: misaligned target; flagged only when the check is built in
        cyc("t6.br", 0, 0, 1, 64'h102, 1);
        for (int i = 0; i < 3; i++) cyc("t6.hold", 0, 0, 0, 64'h0, 1);
        cyc("t6.rst", 1, 0, 0, 64'h0, 1);
        chk("t6.mis_clr", 64'(bus0.MISALIGN), 64'd0);
        cyc("t6.boot", 0, 0, 0, 64'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
